// File: rtl/fft_share_arb.sv
// Frame arbiter for a shared FFT core: grants whole NFFT-sample frames to A (IFFT) or B (FFT),
// sends the per-frame config word, and routes core output frames back via an ownership tag FIFO.
module fft_share_arb #(
  parameter int         NFFT      = 64,
  parameter int         LOG2N     = 6,
  parameter logic [5:0] SCALE_A   = 6'b000011,
  parameter logic [5:0] SCALE_B   = 6'b101011,
  parameter int         TAG_DEPTH = 4
) (
  input  logic        CLK_I,
  input  logic        RSTN_I,
  input  logic        A_CYC_I,
  input  logic        A_STB_I,
  input  logic [31:0] A_DAT_I,
  output logic        A_ACK_O,
  input  logic        B_CYC_I,
  input  logic        B_STB_I,
  input  logic [31:0] B_DAT_I,
  output logic        B_ACK_O,
  output logic [7:0]  CFG_TDATA_O,
  output logic        CFG_TVALID_O,
  input  logic        CFG_TREADY_I,
  output logic [31:0] S_TDATA_O,
  output logic        S_TVALID_O,
  input  logic        S_TREADY_I,
  output logic        S_TLAST_O,
  input  logic [31:0] M_TDATA_I,
  input  logic        M_TVALID_I,
  input  logic        M_TLAST_I,
  output logic        M_TREADY_O,
  output logic [31:0] A_DAT_O,
  output logic [31:0] B_DAT_O,
  output logic        A_STB_O,
  output logic        B_STB_O,
  input  logic        A_ACK_I,
  input  logic        B_ACK_I,
  output logic        BUSY_O,
  output logic        ERR_O
);

  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CFG, ST_DATA} state_t;

  state_t           state_reg, state_next;
  logic             own_reg, own_next;          // 0 = A, 1 = B
  logic             last_own_reg, last_own_next;
  logic [LOG2N-1:0] cnt_reg, cnt_next;
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             tag_mem [TAG_DEPTH];
  logic             err_reg;

  logic req_a, req_b, full, empty, head, push, pop;

  assign req_a = A_CYC_I & A_STB_I;
  assign req_b = B_CYC_I & B_STB_I;
  assign full  = (count_reg == CW'(TAG_DEPTH));
  assign empty = (count_reg == '0);
  assign head  = tag_mem[rd_ptr_reg];

  always_comb begin
    state_next    = state_reg;
    own_next      = own_reg;
    last_own_next = last_own_reg;
    cnt_next      = cnt_reg;
    push          = 1'b0;
    CFG_TVALID_O  = 1'b0;
    CFG_TDATA_O   = '0;
    S_TDATA_O     = '0;
    S_TVALID_O    = 1'b0;
    S_TLAST_O     = 1'b0;
    A_ACK_O       = 1'b0;
    B_ACK_O       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!full && (req_a || req_b)) begin
          own_next      = (req_a && req_b) ? ~last_own_reg : req_b;
          last_own_next = own_next;
          push          = 1'b1;
          state_next    = ST_CFG;
        end
      end
      ST_CFG: begin
        CFG_TVALID_O = 1'b1;
        CFG_TDATA_O  = own_reg ? {1'b0, SCALE_B, 1'b1} : {1'b0, SCALE_A, 1'b0};
        if (CFG_TREADY_I) begin
          state_next = ST_DATA;
          cnt_next   = '0;
        end
      end
      ST_DATA: begin
        S_TDATA_O  = own_reg ? B_DAT_I : A_DAT_I;
        S_TVALID_O = own_reg ? req_b : req_a;
        S_TLAST_O  = (cnt_reg == LOG2N'(NFFT - 1));
        A_ACK_O    = ~own_reg & S_TREADY_I;
        B_ACK_O    = own_reg & S_TREADY_I;
        if (S_TVALID_O && S_TREADY_I) begin
          cnt_next = cnt_reg + LOG2N'(1);
          if (S_TLAST_O) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output side: head tag selects the consumer; with no tag the sample is swallowed and flagged.
  assign A_DAT_O    = M_TDATA_I;
  assign B_DAT_O    = M_TDATA_I;
  assign A_STB_O    = M_TVALID_I & ~empty & ~head;
  assign B_STB_O    = M_TVALID_I & ~empty & head;
  assign M_TREADY_O = RSTN_I & (empty ? M_TVALID_I : (head ? B_ACK_I : A_ACK_I));
  assign pop        = M_TVALID_I & M_TREADY_O & M_TLAST_I & ~empty;
  assign BUSY_O     = (state_reg != ST_IDLE);
  assign ERR_O      = err_reg;

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      state_reg    <= ST_IDLE;
      own_reg      <= 1'b0;
      last_own_reg <= 1'b1;
      cnt_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      own_reg      <= own_next;
      last_own_reg <= last_own_next;
      cnt_reg      <= cnt_next;
      err_reg      <= err_reg | (M_TVALID_I & empty);
      if (push) wr_ptr_reg <= (wr_ptr_reg == PW'(TAG_DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= (rd_ptr_reg == PW'(TAG_DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge CLK_I) begin
    if (push) tag_mem[wr_ptr_reg] <= own_next;
  end

endmodule

// File: doc/fft_share_arb.md
# fft_share_arb

Frame-level arbiter and configurator that time-shares the single FFT core between two requesters in the OFDM PHY: requester A (TX IFFT path) and requester B (RX FFT path). It grants the core for one complete NFFT-sample frame, issues that frame's direction and scaling word on the core's config channel, and streams the owner's samples into the core. A tag FIFO records frame ownership so each output frame is routed back to the requester that supplied it.

## Interface
- NFFT, 64, transform length in samples (power of 2).
- LOG2N, 6, log2(NFFT); sample counter width.
- SCALE_A, 6'b000011, scale schedule for A frames.
- SCALE_B, 6'b101011, scale schedule for B frames.
- TAG_DEPTH, 4, ownership FIFO depth: maximum frames in flight.

Ports:
- CLK_I  in  1  clock.
- RSTN_I  in  1  asynchronous active-low reset.
- A_CYC_I, A_STB_I  in  1  A requests and presents a valid sample.
- A_DAT_I  in  32  A sample, {Im[31:16], Re[15:0]}.
- A_ACK_O  out  1  A sample accepted this cycle.
- B_CYC_I, B_STB_I, B_DAT_I, B_ACK_O: same as the A ports, for B.
- CFG_TDATA_O  out  8  {1'b0, SCALE[5:0], FWD}.
- CFG_TVALID_O  out  1  config word valid.
- CFG_TREADY_I  in  1  core accepts config word.
- S_TDATA_O  out  32  sample to core.
- S_TVALID_O  out  1  sample valid.
- S_TREADY_I  in  1  core accepts sample.
- S_TLAST_O  out  1  last sample of frame.
- M_TDATA_I  in  32  core output sample.
- M_TVALID_I, M_TLAST_I  in  1  core output valid; last sample of output frame.
- M_TREADY_O  out  1  output sample consumed.
- A_DAT_O, B_DAT_O  out  32  routed output samples; both equal M_TDATA_I.
- A_STB_O, B_STB_O  out  1  routed output valid.
- A_ACK_I, B_ACK_I  in  1  consumer ready.
- BUSY_O  out  1  state is not IDLE.
- ERR_O  out  1  sticky: output sample arrived with no tag.

## Operation
- **Request:** REQ_X = X_CYC_I & X_STB_I.
- **FSM states:** IDLE, CFG, DATA.
- **IDLE:** if the tag FIFO is not full and any REQ is high, grant the core.
  - If both request, the grant goes to the requester other than `last_own`.
  - `last_own` resets to B, so A wins the first contest.
  - On grant: latch `own`, update `last_own`, push `own` into the tag FIFO, go to CFG.
  - If the tag FIFO is full, remain in IDLE.
- **CFG:** CFG_TVALID_O = 1.
  - CFG_TDATA_O carries FWD = 0 with SCALE_A for an A frame, or FWD = 1 with SCALE_B for a B frame.
  - On CFG_TREADY_I go to DATA and clear `cnt`.
- **DATA (combinational pass-through):**
  - S_TDATA_O = own DAT; S_TVALID_O = own STB_I.
  - own ACK_O = S_TREADY_I; the non-owner ACK_O is 0.
  - Each accepted beat (S_TVALID_O & S_TREADY_I) increments `cnt`.
  - S_TLAST_O = (cnt == NFFT-1).
  - An accepted beat with cnt == NFFT-1 returns to IDLE.
- **Owner stalls:** if the owner drops STB_I or CYC_I mid-frame, the block waits. There is no abort and no timeout.
- **Output routing:** head = tag FIFO head.
  - X_STB_O = M_TVALID_I & ~empty & (head == X).
  - M_TREADY_O = ACK_I of the head requester.
  - Pop the tag FIFO on M_TVALID_I & M_TREADY_O & M_TLAST_I.
- **Unexpected output:** M_TVALID_I with the tag FIFO empty gives M_TREADY_O = 1, the sample is dropped, and ERR_O is set. ERR_O clears only on reset.
- **Simultaneous push and pop:** the count is unchanged and the pointers both advance. Push is impossible when full, so full plus push never occurs.
- **Pointer wrap:** pointers wrap modulo TAG_DEPTH. full = (count == TAG_DEPTH).

## Timing
- **Reset (RSTN_I low, asynchronous):**
  - State goes to IDLE; `cnt`, tag FIFO and ERR_O are cleared; `last_own` is set to B.
  - All outputs go to 0, except X_DAT_O, which follows M_TDATA_I.
  - Reset mid-frame discards the partial frame and all tags.
- **Input latency:**
  - Request seen in IDLE at cycle t gives CFG_TVALID_O at t+1.
  - With TREADY at t+1, the first sample can be accepted at t+2.
  - Sample path latency is 0 cycles (combinational).
- **Frame spacing:** after the last beat at cycle t, the state is IDLE at t+1 and the next grant goes to CFG at t+2. Minimum frame period is NFFT+2 cycles.
- **Output path latency:** 0 cycles, combinational.

## Test plan
- **Single A frame:** only A requests 64 beats with S_TREADY_I held at 1.
  - CFG_TDATA_O = 8'h06; 64 ACKs; S_TLAST_O on beat 63.
  - Back to IDLE at +1; the tag FIFO holds A.
- **Simultaneous requests:** A and B request in the same cycle after reset.
  - A is served first, then B with CFG_TDATA_O = 8'h57.
  - The next contest goes to A; B_ACK_O stays 0 throughout A's frame.
- **Tag FIFO full:** four frames granted with no core output.
  - The fifth request stays in IDLE with BUSY_O = 0.
  - After one M_TLAST_I pop, the grant happens on the next IDLE cycle.
- **Output routing:** output frames tagged A then B, with A_ACK_I toggling.
  - Only A_STB_O pulses during frame 1 and M_TREADY_O tracks A_ACK_I.
  - The switch to B_STB_O occurs exactly after the TLAST handshake.
- **Unexpected output:** M_TVALID_I asserted with the tag FIFO empty.
  - M_TREADY_O = 1 and no STB_O is asserted.
  - ERR_O = 1 from the next cycle and stays set until reset.
- **Reset mid-frame:** RSTN_I low at beat 30 of a B frame.
  - All outputs are 0 immediately and the FIFO is empty.
  - After release, a new A request is granted with `cnt` starting at 0.
